// File: rtl/addr_cam_ctrl.sv
// Request-side controller for one addr_cam: serialises LOOKUP/INSERT/READ/FLUSH commands,
// drives the CAM pins from registered state only and allocates entries sequentially.
module addr_cam_ctrl #(
   parameter int WORD_SIZE   = 16,
   parameter int ENTRY_WIDTH = 7,
   parameter int ROW_NUM     = 68
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [1:0]             req_op,
   input  logic [WORD_SIZE-1:0]   req_data,
   input  logic [ENTRY_WIDTH-1:0] req_addr,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic                   rsp_hit,
   output logic                   rsp_new,
   output logic                   rsp_full,
   output logic                   rsp_err,
   output logic [ENTRY_WIDTH-1:0] rsp_addr,
   output logic [WORD_SIZE-1:0]   rsp_data,
   output logic [ENTRY_WIDTH-1:0] occupancy,
   output logic [WORD_SIZE-1:0]   cam_data_in,
   output logic [ENTRY_WIDTH-1:0] cam_addr_in,
   output logic                   cam_read_en,
   output logic                   cam_write_en,
   output logic                   cam_search_en,
   output logic                   cam_reset,
   input  logic [WORD_SIZE-1:0]   cam_data_out,
   input  logic [ENTRY_WIDTH-1:0] cam_addr_out,
   input  logic                   cam_match
);

   localparam logic [1:0] OP_LOOKUP = 2'b00;
   localparam logic [1:0] OP_INSERT = 2'b01;
   localparam logic [1:0] OP_READ   = 2'b10;
   localparam logic [1:0] OP_FLUSH  = 2'b11;

   localparam logic [ENTRY_WIDTH-1:0] ROW_MAX = ENTRY_WIDTH'(ROW_NUM);
   localparam logic [ENTRY_WIDTH-1:0] OCC_ONE = 1;

   typedef enum logic [3:0] {
      S_INIT,
      S_IDLE,
      S_SEARCH,
      S_WRITE,
      S_READ,
      S_RDWAIT,
      S_FLUSH,
      S_FLWAIT,
      S_RESP
   } state_t;

   state_t                   r_state;
   state_t                   w_next;
   logic [1:0]               r_op;
   logic [WORD_SIZE-1:0]     r_data;
   logic [ENTRY_WIDTH-1:0]   r_addr;
   logic [ENTRY_WIDTH-1:0]   r_occ;
   logic                     r_rsp_hit;
   logic                     r_rsp_new;
   logic                     r_rsp_full;
   logic                     r_rsp_err;
   logic [ENTRY_WIDTH-1:0]   r_rsp_addr;
   logic [WORD_SIZE-1:0]     r_rsp_data;
   logic                     w_req_err;
   logic                     w_accept;
   logic                     w_room;

   // Word 0 is what a cleared entry holds, so it can never be searched for or stored.
   assign w_req_err = ((req_op == OP_LOOKUP || req_op == OP_INSERT) && req_data == '0) ||
                      (req_op == OP_READ && req_addr >= ROW_MAX);
   assign w_accept  = req_valid && (r_state == S_IDLE);
   assign w_room    = (r_occ < ROW_MAX);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_INIT;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      req_ready     = 1'b0;
      rsp_valid     = 1'b0;
      cam_data_in   = '0;
      cam_addr_in   = '0;
      cam_read_en   = 1'b0;
      cam_write_en  = 1'b0;
      cam_search_en = 1'b0;
      cam_reset     = 1'b0;
      case (r_state)
         S_INIT: begin
            cam_reset = 1'b1;
            w_next    = S_IDLE;
         end
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (w_req_err) w_next = S_RESP;
               else begin
                  case (req_op)
                     OP_READ:  w_next = S_READ;
                     OP_FLUSH: w_next = S_FLUSH;
                     default:  w_next = S_SEARCH;
                  endcase
               end
            end
         end
         S_SEARCH: begin
            cam_search_en = 1'b1;
            cam_data_in   = r_data;
            if (!cam_match && r_op == OP_INSERT && w_room) w_next = S_WRITE;
            else                                           w_next = S_RESP;
         end
         S_WRITE: begin
            cam_write_en = 1'b1;
            cam_addr_in  = r_occ;
            cam_data_in  = r_data;
            w_next       = S_RESP;
         end
         // The CAM read port is registered: data_out is valid the cycle after read_en.
         S_READ: begin
            cam_read_en = 1'b1;
            cam_addr_in = r_addr;
            w_next      = S_RDWAIT;
         end
         S_RDWAIT: begin
            cam_addr_in = r_addr;
            w_next      = S_RESP;
         end
         S_FLUSH: begin
            cam_reset = 1'b1;
            w_next    = S_FLWAIT;
         end
         S_FLWAIT: w_next = S_RESP;
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) w_next = S_IDLE;
         end
         default: w_next = S_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_op   <= req_op;
         r_data <= req_data;
         r_addr <= req_addr;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_occ      <= '0;
         r_rsp_hit  <= 1'b0;
         r_rsp_new  <= 1'b0;
         r_rsp_full <= 1'b0;
         r_rsp_err  <= 1'b0;
         r_rsp_addr <= '0;
         r_rsp_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) r_rsp_err <= w_req_err;
            S_SEARCH: begin
               if (cam_match) begin
                  r_rsp_hit  <= 1'b1;
                  r_rsp_addr <= cam_addr_out;
               end else if (r_op == OP_INSERT && !w_room) begin
                  r_rsp_full <= 1'b1;
               end
            end
            S_WRITE: begin
               r_rsp_new  <= 1'b1;
               r_rsp_addr <= r_occ;
               r_occ      <= r_occ + OCC_ONE;
            end
            S_RDWAIT: r_rsp_data <= cam_data_out;
            S_FLUSH:  r_occ <= '0;
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_hit  <= 1'b0;
                  r_rsp_new  <= 1'b0;
                  r_rsp_full <= 1'b0;
                  r_rsp_err  <= 1'b0;
                  r_rsp_addr <= '0;
                  r_rsp_data <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_hit   = r_rsp_hit;
   assign rsp_new   = r_rsp_new;
   assign rsp_full  = r_rsp_full;
   assign rsp_err   = r_rsp_err;
   assign rsp_addr  = r_rsp_addr;
   assign rsp_data  = r_rsp_data;
   assign occupancy = r_occ;

endmodule
